// File: rtl/demux6_capture_if.sv
// Bus bundle for demux6_capture: serial bit routing inputs, captured word and status outputs.
// Handshake: a completed word is presented with valid=1 and q held stable; it is consumed at the rising edge where valid && ack.
interface demux6_capture_if;
  logic       din;
  logic [2:0] sel;
  logic       wr;
  logic       start;
  logic       bit_en;
  logic       ack;
  logic [5:0] q;
  logic [2:0] idx;
  logic       busy;
  logic       valid;
  logic       err;
  logic [1:0] state_dbg;

  modport master (
    output din, sel, wr, start, bit_en, ack,
    input  q, idx, busy, valid, err, state_dbg
  );

  modport slave (
    input  din, sel, wr, start, bit_en, ack,
    output q, idx, busy, valid, err, state_dbg
  );
endinterface

// File: rtl/demux6_capture.sv
// Routes a serial bit into one of six word positions, either by addressed write
// or by an automatic 6-bit capture that hands the finished word to a consumer.
module demux6_capture #(
  parameter bit AUTO_RESTART = 1'b0
) (
  input logic            CLOCK_50,
  input logic            reset,
  demux6_capture_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] q_q, q_d;
  logic [2:0] idx_q, idx_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;
  logic       valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    idx_d   = idx_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        // start takes priority over an addressed write in the same cycle
        if (bus.start) begin
          state_d = CAPTURE;
          idx_d   = 3'd0;
          err_d   = 1'b0;
        end else if (bus.wr) begin
          if (bus.sel > 3'd5) begin
            err_d = 1'b1;
          end else begin
            for (int i = 0; i < 6; i++) begin
              if (bus.sel == i[2:0]) q_d[i] = bus.din;
            end
          end
        end
      end
      CAPTURE: begin
        if (bus.bit_en) begin
          for (int i = 0; i < 6; i++) begin
            if (idx_q == i[2:0]) q_d[i] = bus.din;
          end
          if (idx_q == 3'd5) begin
            idx_d   = 3'd0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      DONE: begin
        if (bus.ack) begin
          state_d = AUTO_RESTART ? CAPTURE : IDLE;
          idx_d   = 3'd0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d == CAPTURE);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      q_q     <= 6'b000000;
      idx_q   <= 3'd0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign bus.q         = q_q;
  assign bus.idx       = idx_q;
  assign bus.busy      = busy_q;
  assign bus.valid     = valid_q;
  assign bus.err       = err_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_demux6_capture.sv
// Bench for demux6_capture: one instance per AUTO_RESTART setting, shared stimulus,
// a per-cycle output scoreboard and a completed-word scoreboard fed by a reference model.
module tb_demux6_capture;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       din      = 1'b0;
  logic [2:0] sel      = 3'd0;
  logic       wr       = 1'b0;
  logic       start    = 1'b0;
  logic       bit_en   = 1'b0;
  logic       ack      = 1'b0;

  always #5 CLOCK_50 = ~CLOCK_50;

  demux6_capture_if if0 ();
  demux6_capture_if if1 ();

  assign if0.din = din;  assign if0.sel = sel;  assign if0.wr = wr;
  assign if0.start = start;  assign if0.bit_en = bit_en;  assign if0.ack = ack;
  assign if1.din = din;  assign if1.sel = sel;  assign if1.wr = wr;
  assign if1.start = start;  assign if1.bit_en = bit_en;  assign if1.ack = ack;

  demux6_capture #(.AUTO_RESTART(1'b0)) dut0 (.CLOCK_50(CLOCK_50), .reset(reset), .bus(if0));
  demux6_capture #(.AUTO_RESTART(1'b1)) dut1 (.CLOCK_50(CLOCK_50), .reset(reset), .bus(if1));

  int n_checks = 0;
  int n_pass   = 0;

  // expected {q, idx, busy, valid, err} per cycle, and expected completed words
  logic [11:0] exp_q0[$];
  logic [11:0] exp_q1[$];
  logic [5:0]  exp_w0[$];
  logic [5:0]  exp_w1[$];

  // reference model: mode 0 = waiting, 1 = collecting bits, 2 = word ready
  int         m_mode[2];
  logic [5:0] m_word[2];
  int         m_pos[2];
  bit         m_err[2];

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  function automatic logic [11:0] model_out(input int k);
    logic [2:0] p;
    p = 3'(m_pos[k]);
    return {m_word[k], p, m_mode[k] == 1, m_mode[k] == 2, m_err[k]};
  endfunction

  function automatic void model_step(input int k, input bit ar);
    int prev;
    prev = m_mode[k];
    if (reset) begin
      m_mode[k] = 0; m_word[k] = '0; m_pos[k] = 0; m_err[k] = 0;
      return;
    end
    if (prev == 0) begin
      if (start) begin
        m_mode[k] = 1; m_pos[k] = 0; m_err[k] = 0;
      end else if (wr) begin
        if (int'(sel) < 6) m_word[k][sel] = din;
        else m_err[k] = 1;
      end
    end else if (prev == 1) begin
      if (bit_en) begin
        m_word[k][m_pos[k]] = din;
        m_pos[k] = (m_pos[k] + 1) % 6;
        if (m_pos[k] == 0) m_mode[k] = 2;
      end
    end else if (ack) begin
      m_mode[k] = ar ? 1 : 0;
      m_pos[k]  = 0;
    end
    if (m_mode[k] == 2 && prev != 2) begin
      if (k == 0) exp_w0.push_back(m_word[k]);
      else        exp_w1.push_back(m_word[k]);
    end
  endfunction

  task automatic step(input bit r, input bit d, input logic [2:0] s, input bit w,
                      input bit st, input bit be, input bit a);
    reset = r; din = d; sel = s; wr = w; start = st; bit_en = be; ack = a;
    @(posedge CLOCK_50);
    model_step(0, 1'b0);
    model_step(1, 1'b1);
    exp_q0.push_back(model_out(0));
    exp_q1.push_back(model_out(1));
    @(negedge CLOCK_50);
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick(input bit d);
    step(0, d, 0, 0, 0, 1, 0);
  endtask

  function automatic logic [11:0] pack0();
    return {if0.q, if0.idx, if0.busy, if0.valid, if0.err};
  endfunction

  function automatic logic [11:0] pack1();
    return {if1.q, if1.idx, if1.busy, if1.valid, if1.err};
  endfunction

  // per-cycle monitors
  always @(negedge CLOCK_50) begin
    if (exp_q0.size() > 0) check("cycle_dut0", pack0(), exp_q0.pop_front());
    if (exp_q1.size() > 0) check("cycle_dut1", pack1(), exp_q1.pop_front());
  end

  // completed-word monitors, triggered by the rising valid
  logic prev_v0 = 1'b0;
  logic prev_v1 = 1'b0;
  always @(negedge CLOCK_50) begin
    if (if0.valid === 1'b1 && prev_v0 !== 1'b1) begin
      if (exp_w0.size() == 0) check("word_unexpected_dut0", {6'd0, if0.q}, 12'hfff);
      else check("word_dut0", {6'd0, if0.q}, {6'd0, exp_w0.pop_front()});
    end
    if (if1.valid === 1'b1 && prev_v1 !== 1'b1) begin
      if (exp_w1.size() == 0) check("word_unexpected_dut1", {6'd0, if1.q}, 12'hfff);
      else check("word_dut1", {6'd0, if1.q}, {6'd0, exp_w1.pop_front()});
    end
    prev_v0 = if0.valid;
    prev_v1 = if1.valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] wpat;
    logic [5:0] cpat;
    for (int i = 0; i < 6; i++) begin
      m_mode[i % 2] = 0; m_word[i % 2] = '0; m_pos[i % 2] = 0; m_err[i % 2] = 0;
    end
    @(negedge CLOCK_50);
    step(1, 1, 3'd2, 1, 1, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    check("reset_dut0", pack0(), 12'd0);
    check("reset_dut1", pack1(), 12'd0);

    // addressed writes sel 0..5
    wpat = 6'b101101;
    for (int i = 0; i < 6; i++) step(0, wpat[i], 3'(i), 1, 0, 0, 0);
    check("wr_word", pack0(), {6'b101101, 3'd0, 1'b0, 1'b0, 1'b0});

    // illegal address sets err, start clears it
    step(0, 1, 3'd6, 1, 0, 0, 0);
    check("wr_illegal", pack0(), {6'b101101, 3'd0, 1'b0, 1'b0, 1'b1});
    step(0, 1, 3'd1, 1, 1, 1, 0);
    check("start_clears_err", pack0(), {6'b101101, 3'd0, 1'b1, 1'b0, 1'b0});

    // six-tick capture
    cpat = 6'b010011;
    for (int i = 0; i < 5; i++) tick(cpat[i]);
    check("valid_not_early", {11'd0, if0.valid}, 12'd0);
    tick(cpat[5]);
    check("capture_word", pack0(), {6'b010011, 3'd0, 1'b0, 1'b1, 1'b0});
    for (int i = 0; i < 3; i++) step(0, 1, 3'd0, 1, 1, 1, 0);
    check("done_holds", pack0(), {6'b010011, 3'd0, 1'b0, 1'b1, 1'b0});
    step(0, 1, 0, 0, 0, 1, 1);
    check("ack_idle", pack0(), {6'b010011, 3'd0, 1'b0, 1'b0, 1'b0});
    check("ack_restart", {10'd0, if1.busy, if1.valid}, 12'b10);

    // second word on the auto-restarting instance
    cpat = 6'b110110;
    for (int i = 0; i < 6; i++) tick(cpat[i]);
    check("restart_word", pack1(), {6'b110110, 3'd0, 1'b0, 1'b1, 1'b0});
    check("idle_ignores_ticks", {6'd0, if0.q}, {6'd0, 6'b010011});
    step(0, 0, 0, 0, 0, 0, 1);

    // capture with bit_en gaps
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    tick(1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    check("gap_idx_hold", {9'd0, if0.idx}, 12'd1);
    tick(1);
    step(0, 0, 0, 0, 0, 0, 0);
    tick(0);
    tick(0);
    step(0, 1, 0, 0, 0, 0, 0);
    tick(1);
    step(0, 1, 0, 0, 0, 0, 0);
    tick(0);
    check("gap_word", pack0(), {6'b010011, 3'd0, 1'b0, 1'b1, 1'b0});
    step(0, 0, 0, 0, 0, 0, 1);

    // reset mid-capture
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    tick(1); tick(1); tick(1);
    check("partial_idx", {9'd0, if0.idx}, 12'd3);
    step(1, 1, 0, 0, 0, 1, 0);
    check("mid_reset_dut0", pack0(), 12'd0);
    check("mid_reset_dut1", pack1(), 12'd0);
    step(0, 0, 0, 0, 1, 0, 0);
    cpat = 6'b111001;
    for (int i = 0; i < 6; i++) tick(cpat[i]);
    check("post_reset_word", pack0(), {6'b111001, 3'd0, 1'b0, 1'b1, 1'b0});
    step(0, 0, 0, 0, 0, 0, 1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
    end

    idle_step();
    idle_step();
    check("words_drained", 12'(exp_w0.size() + exp_w1.size()), 12'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/demux6_capture.md
DEMUX6_CAPTURE -- requirements
Module: demux6_capture

Interface
REQ-001 Parameter AUTO_RESTART, default 0: when 1, acknowledging a completed word immediately starts the next capture.
REQ-002 CLOCK_50  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 din  input  1  serial data bit to be routed into one of six word positions.
REQ-005 sel  input  3  target position for addressed writes; legal values 0..5.
REQ-006 wr  input  1  addressed-write strobe: q[sel] <= din.
REQ-007 start  input  1  begin automatic 6-bit capture.
REQ-008 bit_en  input  1  bit-time tick; one bit captured per high cycle during capture.
REQ-009 ack  input  1  consumer acknowledges the completed word.
REQ-010 q  output  6  captured word; q[i] holds the bit routed to position i.
REQ-011 idx  output  3  position the next automatic capture writes.
REQ-012 busy  output  1  high while an automatic capture is in progress.
REQ-013 valid  output  1  high while a completed word awaits ack.
REQ-014 err  output  1  sticky flag: illegal addressed write attempted.

Function
REQ-015 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-016 The FSM SHALL have three states: IDLE, CAPTURE, DONE; busy = (state==CAPTURE); valid = (state==DONE).
REQ-017 IDLE, wr=1, start=0, sel in 0..5: q[sel] <= din at that edge; the other five q bits are unchanged.
REQ-018 IDLE, wr=1, start=0, sel in 6..7: q unchanged; err <= 1.
REQ-019 IDLE, start=1: next state CAPTURE, idx <= 0, err <= 0; wr in the same cycle is ignored (start wins).
REQ-020 The bit_en value in the cycle start is sampled SHALL NOT capture a bit.
REQ-021 CAPTURE, bit_en=1: q[idx] <= din; idx <= idx+1.
REQ-022 CAPTURE, bit_en=1, idx==5: q[5] <= din, idx <= 0, next state DONE.
REQ-023 CAPTURE, bit_en=0: q, idx and state hold.
REQ-024 Bits q[i] for i >= idx SHALL retain prior contents until overwritten during capture.
REQ-025 valid rises the edge after the sixth captured bit; q SHALL be stable for the whole time valid is high.
REQ-026 DONE, ack=1, AUTO_RESTART=0: next state IDLE; valid falls at that edge.
REQ-027 DONE, ack=1, AUTO_RESTART=1: next state CAPTURE with idx=0; valid falls and busy rises at that edge; bit_en in that cycle is not captured.
REQ-028 DONE, ack=0: state, q, and idx hold indefinitely.
REQ-029 wr and start SHALL be ignored in CAPTURE and DONE; err SHALL be unaffected.
REQ-030 ack SHALL be ignored in IDLE and CAPTURE.
REQ-031 idx SHALL never exceed 5; it wraps from 5 back to 0 only through the transition to DONE.

Reset
REQ-032 reset=1 at a rising edge SHALL force state IDLE, q=6'b000000, idx=0, busy=0, valid=0, err=0, regardless of state or other inputs.
REQ-033 Reset during CAPTURE or DONE SHALL discard the partial or completed word; no valid pulse follows.
REQ-034 The first edge with reset=0 SHALL process inputs normally.

Verification
REQ-035 Bench: reset, then wr with sel=0..5 and din=1,0,1,1,0,1 in turn -> q=6'b101101, err=0, busy=0.
REQ-036 Bench: IDLE, wr=1 sel=6 din=1 -> q unchanged, err=1; then start -> err=0.
REQ-037 Bench: start, then bit_en high for six cycles with din=1,1,0,0,1,0 -> q=6'b010011, valid=1 exactly one edge after the sixth tick; ack -> valid=0, state IDLE.
REQ-038 Bench: bit_en gaps during capture (pattern 1,0,0,1,...) -> idx advances only on ticks; the result matches the gap-free run.
REQ-039 Bench: AUTO_RESTART=1, ack in DONE -> busy=1 on the same edge valid=0; a second six-tick word is captured correctly.
REQ-040 Bench: reset asserted after three captured bits -> all outputs zero next edge; a subsequent full capture yields the correct word.
